pipeline_hazard_ctrl: RTL and testbench

//  Stall/flush sequencer for the 5-stage MIPS pipeline; companion to the forwarding unit.
//  - Detects hazards that forwarding cannot cover: load-use and load-to-jr.
//  - Sequences the multi-cycle MULT/DIV unit.
//  - Orders interrupt entry against in-flight branches and stalls.
//  - Drives PC/IF_ID hold and IF_ID/ID_EX flush (bubble) controls.

---
 rtl/mips_pipe_pkg.sv | 21 ++
 rtl/pipeline_hazard_ctrl_if.sv | 41 ++++
 rtl/md_busy_counter.sv | 33 +++
 rtl/pipeline_hazard_ctrl.sv | 86 ++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared encodings for the 5-stage MIPS pipeline control blocks.
// PC select codes and interrupt sequencer states.
package mips_pipe_pkg;

    typedef enum logic [2:0] {
        PC_PLUS4 = 3'b000,
        PC_BR    = 3'b001,
        PC_J     = 3'b010,
        PC_JR    = 3'b011,
        PC_ILLOP = 3'b100,
        PC_XADR  = 3'b101
    } pcsrc_e;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_TAKE = 2'd2,
        ST_HOLD = 2'd3
    } irq_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between ID/EX/MEM pipeline regs and the controller.
// master = pipeline datapath side, slave = hazard controller.
interface pipeline_hazard_ctrl_if;
    logic [2:0] PCSrc;
    logic [4:0] RS_IF_ID;
    logic [4:0] RT_IF_ID;
    logic       RegWrite_ID_EX;
    logic       MemRead_ID_EX;
    logic [4:0] AddrC_ID_EX;
    logic       MemRead_EX_MEM;
    logic [4:0] AddrC_EX_MEM;
    logic       branch_taken_EX;
    logic       md_start_ID;
    logic       md_read_ID;
    logic       irq;
    logic       stall_PC;
    logic       stall_IF_ID;
    logic       flush_IF_ID;
    logic       flush_ID_EX;
    logic       md_go;
    logic       md_busy;
    logic       irq_take;

    modport master (
        output PCSrc, RS_IF_ID, RT_IF_ID,
        output RegWrite_ID_EX, MemRead_ID_EX, AddrC_ID_EX,
        output MemRead_EX_MEM, AddrC_EX_MEM,
        output branch_taken_EX, md_start_ID, md_read_ID, irq,
        input  stall_PC, stall_IF_ID, flush_IF_ID, flush_ID_EX,
        input  md_go, md_busy, irq_take
    );

    modport slave (
        input  PCSrc, RS_IF_ID, RT_IF_ID,
        input  RegWrite_ID_EX, MemRead_ID_EX, AddrC_ID_EX,
        input  MemRead_EX_MEM, AddrC_EX_MEM,
        input  branch_taken_EX, md_start_ID, md_read_ID, irq,
        output stall_PC, stall_IF_ID, flush_IF_ID, flush_ID_EX,
        output md_go, md_busy, irq_take
    );
endinterface

// File: rtl/md_busy_counter.sv
// Busy window for the multi-cycle MULT/DIV unit.
// load starts a MD_LATENCY-cycle countdown; busy while nonzero.
module md_busy_counter #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic busy
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load && cnt_q == '0)
            cnt_d = CNT_W'(MD_LATENCY);
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use, load-to-jr, MULT/DIV busy and
// interrupt entry ordering for the 5-stage MIPS pipeline.
module pipeline_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6
) (
    input logic                  clk,
    input logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);

    irq_state_e state_q;
    irq_state_e state_d;

    logic lu;
    logic jrh;
    logic mdh;
    logic take;
    logic stall;
    logic busy;
    logic go;
    logic is_jump;

    md_busy_counter #(
        .MD_LATENCY(MD_LATENCY),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .load (go),
        .busy (busy)
    );

    // $0 is hardwired, so a zero destination never creates a dependency
    always_comb begin
        lu  = hz.MemRead_ID_EX && hz.AddrC_ID_EX != 5'd0 &&
              (hz.AddrC_ID_EX == hz.RS_IF_ID ||
               hz.AddrC_ID_EX == hz.RT_IF_ID);
        jrh = hz.PCSrc == PC_JR && hz.RS_IF_ID != 5'd0 &&
              ((hz.RegWrite_ID_EX && hz.MemRead_ID_EX &&
                hz.AddrC_ID_EX == hz.RS_IF_ID) ||
               (hz.MemRead_EX_MEM &&
                hz.AddrC_EX_MEM == hz.RS_IF_ID));
        mdh = busy && (hz.md_start_ID || hz.md_read_ID);
    end

    assign take    = (state_q == ST_TAKE);
    assign stall   = (lu || jrh || mdh) && !hz.branch_taken_EX && !take;
    assign is_jump = (hz.PCSrc == PC_J) || (hz.PCSrc == PC_JR);
    assign go      = hz.md_start_ID && !busy && !stall &&
                     !hz.branch_taken_EX && !take && reset;

    always_comb begin
        hz.stall_PC    = stall;
        hz.stall_IF_ID = stall;
        hz.flush_ID_EX = stall || hz.branch_taken_EX || take;
        hz.flush_IF_ID = hz.branch_taken_EX || take ||
                         (is_jump && !stall);
        hz.md_go       = go;
        hz.md_busy     = busy;
        hz.irq_take    = take;
    end

    // WAIT holds a latched request until the pipe is quiet
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:  if (hz.irq) state_d = ST_WAIT;
            ST_WAIT: if (!stall && !hz.branch_taken_EX && !busy)
                         state_d = ST_TAKE;
            ST_TAKE: state_d = ST_HOLD;
            ST_HOLD: if (!hz.irq) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with MD_LATENCY=4.
// Expected output vectors are queued per cycle and checked by a monitor.
module tb_pipeline_hazard_ctrl;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    typedef struct {
        string      nm;
        logic [6:0] v;
    } exp_t;

    exp_t q[$];

    pipeline_hazard_ctrl_if hz();

    pipeline_hazard_ctrl #(
        .MD_LATENCY(4),
        .CNT_W     (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall_PC, stall_IF_ID, flush_IF_ID, flush_ID_EX, md_go, md_busy, irq_take}
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [6:0] act;
            e   = q.pop_front();
            act = {hz.stall_PC, hz.stall_IF_ID, hz.flush_IF_ID,
                   hz.flush_ID_EX, hz.md_go, hz.md_busy, hz.irq_take};
            n_chk++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.nm, act, e.v);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [2:0] pc,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic rw, input logic mr,
                       input logic [4:0] ac,
                       input logic mrm, input logic [4:0] acm,
                       input logic br, input logic ms,
                       input logic mrd, input logic iq);
        hz.PCSrc           = pc;
        hz.RS_IF_ID        = rs;
        hz.RT_IF_ID        = rt;
        hz.RegWrite_ID_EX  = rw;
        hz.MemRead_ID_EX   = mr;
        hz.AddrC_ID_EX     = ac;
        hz.MemRead_EX_MEM  = mrm;
        hz.AddrC_EX_MEM    = acm;
        hz.branch_taken_EX = br;
        hz.md_start_ID     = ms;
        hz.md_read_ID      = mrd;
        hz.irq             = iq;
    endtask

    task automatic idle(input logic iq);
        drv(3'b000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,
            1'b0, 1'b0, 1'b0, iq);
    endtask

    task automatic expect_v(input string nm, input logic [6:0] v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        q.push_back(e);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b0;
        idle(1'b0);

        // in reset: md_go must be gated even with a MULT in ID
        tick();
        drv(3'b000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,
            1'b0, 1'b1, 1'b0, 1'b0);
        expect_v("reset", 7'b0000000);
        tick();
        reset = 1'b1;
        idle(1'b0);
        expect_v("post_reset_idle", 7'b0000000);

        // 1: lw $8 ; add $9,$8,$1
        tick();
        drv(3'b000, 5'd8, 5'd1, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0,
            1'b0, 1'b0, 1'b0, 1'b0);
        expect_v("lu_stall", 7'b1101000);
        tick();
        drv(3'b000, 5'd8, 5'd1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8,
            1'b0, 1'b0, 1'b0, 1'b0);
        expect_v("lu_release", 7'b0000000);

        // 2: lw $31 ; jr $31 -> two stalls then delay-slot flush
        tick();
        drv(3'b011, 5'd31, 5'd0, 1'b1, 1'b1, 5'd31, 1'b0, 5'd0,
            1'b0, 1'b0, 1'b0, 1'b0);
        expect_v("jr_ld_stall1", 7'b1101000);
        tick();
        drv(3'b011, 5'd31, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd31,
            1'b0, 1'b0, 1'b0, 1'b0);
        expect_v("jr_ld_stall2", 7'b1101000);
        tick();
        drv(3'b011, 5'd31, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,
            1'b0, 1'b0, 1'b0, 1'b0);
        expect_v("jr_ld_go", 7'b0010000);
        // add $31 ; jr $31 -> forwarded, no stall
        tick();
        drv(3'b011, 5'd31, 5'd0, 1'b1, 1'b0, 5'd31, 1'b0, 5'd0,
            1'b0, 1'b0, 1'b0, 1'b0);
        expect_v("jr_alu_nostall", 7'b0010000);
        tick();
        drv(3'b010, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,
            1'b0, 1'b0, 1'b0, 1'b0);
        expect_v("j_flush", 7'b0010000);

        // 3: register zero never hazards
        tick();
        drv(3'b000, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0,
            1'b0, 1'b0, 1'b0, 1'b0);
        expect_v("reg0_lu", 7'b0000000);
        tick();
        drv(3'b011, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0,
            1'b0, 1'b0, 1'b0, 1'b0);
        expect_v("reg0_jr", 7'b0010000);

        // 4: MULT then MFLO
        tick();
        drv(3'b000, 5'd2, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,
            1'b0, 1'b1, 1'b0, 1'b0);
        expect_v("mult_go", 7'b0000100);
        for (int i = 0; i < 4; i++) begin
            tick();
            drv(3'b000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,
                1'b0, 1'b0, 1'b1, 1'b0);
            expect_v($sformatf("mflo_stall%0d", i), 7'b1101010);
        end
        tick();
        drv(3'b000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,
            1'b0, 1'b0, 1'b1, 1'b0);
        expect_v("mflo_issue", 7'b0000000);
        tick();
        drv(3'b000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,
            1'b0, 1'b1, 1'b0, 1'b0);
        expect_v("mult2_go", 7'b0000100);
        tick();
        drv(3'b000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,
            1'b0, 1'b1, 1'b0, 1'b0);
        expect_v("mult_busy_nogo", 7'b1101010);
        for (int i = 0; i < 3; i++) begin
            tick();
            idle(1'b0);
            expect_v($sformatf("busy_tail%0d", i), 7'b0000010);
        end
        tick();
        idle(1'b0);
        expect_v("busy_done", 7'b0000000);

        // 5: load-use coincident with taken branch
        tick();
        drv(3'b000, 5'd8, 5'd0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0,
            1'b1, 1'b1, 1'b0, 1'b0);
        expect_v("lu_vs_branch", 7'b0011000);

        // 6: irq during MULT busy
        tick();
        drv(3'b000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,
            1'b0, 1'b1, 1'b0, 1'b0);
        expect_v("irq_mult_go", 7'b0000100);
        for (int i = 0; i < 4; i++) begin
            tick();
            idle(1'b1);
            expect_v($sformatf("irq_wait%0d", i), 7'b0000010);
        end
        tick();
        idle(1'b1);
        expect_v("irq_busy_fell", 7'b0000000);
        // TAKE suppresses the load-use stall and md_go
        tick();
        drv(3'b000, 5'd8, 5'd0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0,
            1'b0, 1'b1, 1'b0, 1'b1);
        expect_v("irq_take", 7'b0011001);
        for (int i = 0; i < 10; i++) begin
            tick();
            idle(1'b1);
            expect_v($sformatf("irq_hold%0d", i), 7'b0000000);
        end
        tick();
        idle(1'b0);
        expect_v("irq_release", 7'b0000000);
        tick();
        idle(1'b0);
        expect_v("irq_run", 7'b0000000);

        // reset while WAIT with MULT busy
        tick();
        drv(3'b000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,
            1'b0, 1'b1, 1'b0, 1'b1);
        expect_v("rst_mult_go", 7'b0000100);
        tick();
        idle(1'b0);
        expect_v("rst_wait_busy", 7'b0000010);
        tick();
        reset = 1'b0;
        drv(3'b000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,
            1'b0, 1'b1, 1'b0, 1'b0);
        expect_v("rst_mid", 7'b0000000);
        tick();
        reset = 1'b1;
        idle(1'b0);
        expect_v("rst_after0", 7'b0000000);
        for (int i = 1; i < 4; i++) begin
            tick();
            idle(1'b0);
            expect_v($sformatf("rst_after%0d", i), 7'b0000000);
        end

        begin
            int budget;
            budget = 20;
            while (q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (q.size() > 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL drain: got %0d pending expected 0",
                         q.size());
            end
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
